// File: rtl/cp0_regfile_pkg.sv
//============================================================================
// Module   : cp0_regfile_pkg
// Desc     : CP0 register numbers, ExcCode values and Status/Cause bit
//            positions shared by the CP0 block and the writeback stage.
// Revision : 1.0  initial release
//============================================================================
`default_nettype none

package cp0_regfile_pkg;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int STATUS_IE  = 0;
  localparam int STATUS_EXL = 1;
  localparam int STATUS_IM  = 8;
  localparam int STATUS_BEV = 22;
  localparam int CAUSE_EXC  = 2;
  localparam int CAUSE_IP   = 8;
  localparam int CAUSE_TI   = 30;
  localparam int CAUSE_BD   = 31;

  function automatic logic [31:0] pack_status(input logic [7:0] im,
                                              input logic exl,
                                              input logic ie);
    logic [31:0] v;
    v             = '0;
    v[STATUS_BEV] = 1'b1;
    v[15:8]       = im;
    v[STATUS_EXL] = exl;
    v[STATUS_IE]  = ie;
    return v;
  endfunction

  function automatic logic [31:0] pack_cause(input logic bd,
                                             input logic ti,
                                             input logic [7:0] ip,
                                             input logic [4:0] exccode);
    logic [31:0] v;
    v           = '0;
    v[CAUSE_BD] = bd;
    v[CAUSE_TI] = ti;
    v[15:8]     = ip;
    v[6:2]      = exccode;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cp0_regfile_if.sv
//============================================================================
// Module   : cp0_regfile_if
// Desc     : Writeback-stage to CP0 read/write/exception/eret interface.
// Revision : 1.0  initial release
//============================================================================
`default_nettype none

interface cp0_regfile_if;
  logic [4:0]  raddr;
  logic [31:0] rdata;
  logic        mtc0_we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        ex;
  logic [4:0]  excode;
  logic        bd;
  logic [31:0] ex_pc;
  logic        badvaddr_we;
  logic [31:0] badvaddr;
  logic        eret;
  logic [5:0]  ext_int;
  logic [31:0] epc;
  logic        status_exl;
  logic        int_req;

  modport master (
    output raddr, mtc0_we, waddr, wdata, ex, excode, bd, ex_pc,
           badvaddr_we, badvaddr, eret, ext_int,
    input  rdata, epc, status_exl, int_req
  );

  modport slave (
    input  raddr, mtc0_we, waddr, wdata, ex, excode, bd, ex_pc,
           badvaddr_we, badvaddr, eret, ext_int,
    output rdata, epc, status_exl, int_req
  );
endinterface

`default_nettype wire

// File: rtl/cp0_regfile_timer.sv
//============================================================================
// Module   : cp0_timer
// Desc     : Count/Compare timer with clock divider and sticky TI flag.
// Revision : 1.0  initial release
//============================================================================
`default_nettype none

module cp0_timer #(
  parameter int COUNT_DIV_LOG2 = 1
) (
  input  wire logic        clk,
  input  wire logic        resetn,
  input  wire logic        count_we,
  input  wire logic        compare_we,
  input  wire logic [31:0] wdata,
  output logic      [31:0] count,
  output logic      [31:0] compare,
  output logic             ti
);

  logic w_tick;

  generate
    if (COUNT_DIV_LOG2 > 0) begin : g_div
      logic [COUNT_DIV_LOG2-1:0] r_div;

      // A Count write restarts the prescaler so the next tick is a full period away.
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)       r_div <= '0;
        else if (count_we) r_div <= '0;
        else               r_div <= r_div + COUNT_DIV_LOG2'(1);
      end

      assign w_tick = &r_div;
    end else begin : g_nodiv
      assign w_tick = 1'b1;
    end
  endgenerate

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count   <= '0;
      compare <= '0;
      ti      <= 1'b0;
    end else begin
      if (count_we)    count <= wdata;
      else if (w_tick) count <= count + 32'd1;

      if (compare_we) compare <= wdata;

      if (compare_we)                                ti <= 1'b0;
      else if ((count == compare) && (compare != '0)) ti <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cp0_regfile.sv
//============================================================================
// Module   : cp0_regfile
// Desc     : CP0 responder for WB: mfc0/mtc0, exception/eret state, timer
//            (timer present only when CP0_COUNT_EN is defined).
// Revision : 1.0  initial release
//============================================================================
`default_nettype none

module cp0_regfile
  import cp0_regfile_pkg::*;
#(
  parameter int          COUNT_DIV_LOG2 = 1,
  parameter logic [31:0] RESET_STATUS   = 32'h0040_0000
) (
  input wire logic   clk,
  input wire logic   resetn,
  cp0_regfile_if.slave bus
);

  logic [7:0]  r_status_im;
  logic        r_status_exl;
  logic        r_status_ie;
  logic        r_cause_bd;
  logic [5:0]  r_cause_ip_hw;
  logic [1:0]  r_cause_ip_sw;
  logic [4:0]  r_cause_exccode;
  logic [31:0] r_epc;
  logic [31:0] r_badvaddr;

  logic        w_wr;
  logic [31:0] w_count;
  logic [31:0] w_compare;
  logic        w_ti;
  logic [7:0]  w_cause_ip;
  logic [31:0] w_status;
  logic [31:0] w_cause;

  // An exception in the same cycle swallows any mtc0.
  assign w_wr = bus.mtc0_we && !bus.ex;

`ifdef CP0_COUNT_EN
  cp0_timer #(
    .COUNT_DIV_LOG2 (COUNT_DIV_LOG2)
  ) u_timer (
    .clk        (clk),
    .resetn     (resetn),
    .count_we   (w_wr && (bus.waddr == CP0_COUNT)),
    .compare_we (w_wr && (bus.waddr == CP0_COMPARE)),
    .wdata      (bus.wdata),
    .count      (w_count),
    .compare    (w_compare),
    .ti         (w_ti)
  );
`else
  assign w_count   = '0;
  assign w_compare = '0;
  assign w_ti      = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_status_im     <= RESET_STATUS[15:8];
      r_status_exl    <= RESET_STATUS[STATUS_EXL];
      r_status_ie     <= RESET_STATUS[STATUS_IE];
      r_cause_bd      <= 1'b0;
      r_cause_ip_hw   <= '0;
      r_cause_ip_sw   <= '0;
      r_cause_exccode <= '0;
      r_epc           <= '0;
      r_badvaddr      <= '0;
    end else begin
      r_cause_ip_hw <= bus.ext_int;
      if (bus.ex) begin
        r_status_exl    <= 1'b1;
        r_cause_exccode <= bus.excode;
        if (bus.badvaddr_we) r_badvaddr <= bus.badvaddr;
        // Nested exceptions keep the original return point and BD.
        if (!r_status_exl) begin
          r_epc      <= bus.bd ? (bus.ex_pc - 32'd4) : bus.ex_pc;
          r_cause_bd <= bus.bd;
        end
      end else begin
        if (w_wr && (bus.waddr == CP0_STATUS)) begin
          r_status_im  <= bus.wdata[15:8];
          r_status_exl <= bus.wdata[STATUS_EXL];
          r_status_ie  <= bus.wdata[STATUS_IE];
        end
        if (w_wr && (bus.waddr == CP0_CAUSE)) r_cause_ip_sw <= bus.wdata[9:8];
        if (w_wr && (bus.waddr == CP0_EPC))   r_epc         <= bus.wdata;
        if (bus.eret)                         r_status_exl  <= 1'b0;
      end
    end
  end

  assign w_cause_ip = {r_cause_ip_hw[5] | w_ti, r_cause_ip_hw[4:0], r_cause_ip_sw};
  assign w_status   = pack_status(r_status_im, r_status_exl, r_status_ie);
  assign w_cause    = pack_cause(r_cause_bd, w_ti, w_cause_ip, r_cause_exccode);

  always_comb begin
    bus.rdata = '0;
    case (bus.raddr)
      CP0_BADVADDR: bus.rdata = r_badvaddr;
      CP0_COUNT:    bus.rdata = w_count;
      CP0_COMPARE:  bus.rdata = w_compare;
      CP0_STATUS:   bus.rdata = w_status;
      CP0_CAUSE:    bus.rdata = w_cause;
      CP0_EPC:      bus.rdata = r_epc;
      default:      bus.rdata = '0;
    endcase
  end

  assign bus.epc        = r_epc;
  assign bus.status_exl = r_status_exl;
  assign bus.int_req    = r_status_ie && !r_status_exl && (|(w_cause_ip & r_status_im));

endmodule

`default_nettype wire

// File: tb/tb_cp0_regfile.sv
//============================================================================
// Module   : tb_cp0_regfile
// Desc     : Directed scoreboard bench for cp0_regfile.
// Revision : 1.0  initial release
//============================================================================
`default_nettype none

module tb_cp0_regfile;
  import cp0_regfile_pkg::*;

  localparam int K_RDATA = 0;
  localparam int K_INT   = 1;
  localparam int K_EXL   = 2;
  localparam int K_EPC   = 3;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  cp0_regfile_if bus();

  cp0_regfile #(
    .COUNT_DIV_LOG2 (1),
    .RESET_STATUS   (32'h0040_0000)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  logic [31:0] q_exp[$];
  int          q_kind[$];
  string       q_name[$];
  logic        chk = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;

  // Monitor: pops the expected entry whenever a sample is presented.
  always @(negedge clk) begin
    logic [31:0] act;
    logic [31:0] exp_v;
    int          kind;
    string       name;
    if (chk) begin
      vectors++;
      if (q_exp.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard_empty: sample presented with no expected entry");
      end else begin
        exp_v = q_exp.pop_front();
        kind  = q_kind.pop_front();
        name  = q_name.pop_front();
        case (kind)
          K_RDATA: act = bus.rdata;
          K_INT:   act = {31'b0, bus.int_req};
          K_EXL:   act = {31'b0, bus.status_exl};
          default: act = bus.epc;
        endcase
        if (act !== exp_v) begin
          miscompares++;
          $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
      end
    end
  end

  task automatic check(input int kind, input logic [4:0] addr,
                       input logic [31:0] exp_v, input string name);
    q_exp.push_back(exp_v);
    q_kind.push_back(kind);
    q_name.push_back(name);
    bus.raddr = addr;
    chk = 1'b1;
    @(negedge clk);
    #1;
    chk = 1'b0;
  endtask

  task automatic rd(input logic [4:0] addr, input logic [31:0] exp_v, input string name);
    check(K_RDATA, addr, exp_v, name);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.raddr = '0; bus.mtc0_we = 1'b0; bus.waddr = '0; bus.wdata = '0;
    bus.ex = 1'b0; bus.excode = '0; bus.bd = 1'b0; bus.ex_pc = '0;
    bus.badvaddr_we = 1'b0; bus.badvaddr = '0; bus.eret = 1'b0; bus.ext_int = '0;
  endtask

  task automatic do_ex(input logic [4:0] code, input logic b, input logic [31:0] pc,
                       input logic bvw, input logic [31:0] bva, input logic with_eret);
    bus.ex = 1'b1; bus.excode = code; bus.bd = b; bus.ex_pc = pc;
    bus.badvaddr_we = bvw; bus.badvaddr = bva; bus.eret = with_eret;
    cyc();
    bus.ex = 1'b0; bus.badvaddr_we = 1'b0; bus.eret = 1'b0; bus.bd = 1'b0;
  endtask

  task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
    bus.mtc0_we = 1'b1; bus.waddr = addr; bus.wdata = data;
    cyc();
    bus.mtc0_we = 1'b0;
  endtask

  task automatic eret_pulse();
    bus.eret = 1'b1;
    cyc();
    bus.eret = 1'b0;
  endtask

  initial begin
    idle();
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    cyc();

    rd(CP0_STATUS, 32'h0040_0000, "rst_status");
    rd(CP0_CAUSE, 32'h0, "rst_cause");
    rd(CP0_EPC, 32'h0, "rst_epc");
    rd(CP0_BADVADDR, 32'h0, "rst_badvaddr");
    rd(5'd3, 32'h0, "unmapped_reg");
    check(K_INT, 5'd0, 32'h0, "rst_int_req");
    check(K_EXL, 5'd0, 32'h0, "rst_exl");

    // Syscall then eret
    do_ex(EXC_SYS, 1'b0, 32'hBFC0_0100, 1'b0, 32'h0, 1'b0);
    check(K_EPC, 5'd0, 32'hBFC0_0100, "sys_epc");
    rd(CP0_CAUSE, 32'h0000_0020, "sys_cause");
    check(K_EXL, 5'd0, 32'h1, "sys_exl");
    rd(CP0_STATUS, 32'h0040_0002, "sys_status");
    eret_pulse();
    check(K_EXL, 5'd0, 32'h0, "eret_exl");
    check(K_EPC, 5'd0, 32'hBFC0_0100, "eret_epc");

    // Delay-slot exception, then nested exception with EXL set
    do_ex(EXC_ADEL, 1'b1, 32'h8000_0014, 1'b1, 32'h1234_5677, 1'b0);
    rd(CP0_EPC, 32'h8000_0010, "bd_epc");
    rd(CP0_CAUSE, 32'h8000_0010, "bd_cause");
    rd(CP0_BADVADDR, 32'h1234_5677, "bd_badvaddr");
    do_ex(EXC_OV, 1'b0, 32'h8000_0200, 1'b0, 32'hFFFF_FFFF, 1'b0);
    rd(CP0_EPC, 32'h8000_0010, "nest_epc");
    rd(CP0_CAUSE, 32'h8000_0030, "nest_cause");
    rd(CP0_BADVADDR, 32'h1234_5677, "nest_badvaddr");
    eret_pulse();

    // ex and eret together: ex wins
    do_ex(EXC_BP, 1'b0, 32'h8000_0300, 1'b0, 32'h0, 1'b1);
    check(K_EXL, 5'd0, 32'h1, "ex_eret_exl");
    rd(CP0_CAUSE, 32'h0000_0024, "ex_eret_cause");
    rd(CP0_EPC, 32'h8000_0300, "ex_eret_epc");
    eret_pulse();

    // ex and mtc0 Status together: mtc0 dropped
    mtc0(CP0_STATUS, 32'h0000_0401);
    rd(CP0_STATUS, 32'h0040_0401, "status_wr");
    bus.mtc0_we = 1'b1; bus.waddr = CP0_STATUS; bus.wdata = 32'h0;
    do_ex(EXC_SYS, 1'b0, 32'h8000_0400, 1'b0, 32'h0, 1'b0);
    bus.mtc0_we = 1'b0;
    rd(CP0_STATUS, 32'h0040_0403, "ex_mtc0_status");
    rd(CP0_EPC, 32'h8000_0400, "ex_mtc0_epc");
    eret_pulse();
    rd(CP0_STATUS, 32'h0040_0401, "status_after_eret");

    // Hardware interrupt line 0 with IM2 and IE
    bus.ext_int = 6'b000001;
    cyc();
    check(K_INT, 5'd0, 32'h1, "hw_int_req");
    rd(CP0_CAUSE, 32'h0000_0420, "hw_int_cause");
    bus.ext_int = 6'b000000;
    cyc();
    check(K_INT, 5'd0, 32'h0, "hw_int_clear");

    // Software interrupt bits and write masking
    mtc0(CP0_STATUS, 32'h0000_0101);
    mtc0(CP0_CAUSE, 32'hFFFF_FFFF);
    rd(CP0_CAUSE, 32'h0000_0320, "cause_mask");
    check(K_INT, 5'd0, 32'h1, "sw_int_req");
    mtc0(CP0_CAUSE, 32'h0);
    check(K_INT, 5'd0, 32'h0, "sw_int_clear");
    mtc0(CP0_STATUS, 32'hFFFF_FFFF);
    rd(CP0_STATUS, 32'h0040_FF03, "status_mask");
    check(K_INT, 5'd0, 32'h0, "exl_blocks_int");
    mtc0(CP0_STATUS, 32'h0);
    rd(CP0_STATUS, 32'h0040_0000, "status_clear");

    // Read in the same cycle as a write sees the old value
    cyc();
    bus.mtc0_we = 1'b1; bus.waddr = CP0_EPC; bus.wdata = 32'hDEAD_BEEF;
    rd(CP0_EPC, 32'h8000_0400, "raw_old");
    cyc();
    bus.mtc0_we = 1'b0;
    rd(CP0_EPC, 32'hDEAD_BEEF, "raw_new");

`ifdef CP0_COUNT_EN
    mtc0(CP0_COMPARE, 32'd5);
    mtc0(CP0_COUNT, 32'd0);
    repeat (14) cyc();
    rd(CP0_CAUSE, 32'h4000_8020, "timer_ti");
    rd(CP0_COMPARE, 32'd5, "timer_compare");
    mtc0(CP0_STATUS, 32'h0040_8001);
    check(K_INT, 5'd0, 32'h1, "timer_int_req");
    mtc0(CP0_COMPARE, 32'h100);
    check(K_INT, 5'd0, 32'h0, "timer_ti_clear_int");
    rd(CP0_CAUSE, 32'h0000_0020, "timer_ti_clear_cause");
`else
    mtc0(CP0_COUNT, 32'h55);
    mtc0(CP0_COMPARE, 32'd5);
    repeat (100) cyc();
    rd(CP0_COUNT, 32'h0, "no_timer_count");
    rd(CP0_COMPARE, 32'h0, "no_timer_compare");
    rd(CP0_CAUSE, 32'h0000_0020, "no_timer_cause");
    mtc0(CP0_STATUS, 32'h0040_8001);
    check(K_INT, 5'd0, 32'h0, "no_timer_int_req");
`endif

    // Asynchronous reset mid-operation
    #2;
    resetn = 1'b0;
    check(K_EPC, 5'd0, 32'h0, "midrst_epc");
    rd(CP0_STATUS, 32'h0040_0000, "midrst_status");
    resetn = 1'b1;
    cyc();

    for (int i = 0; i < 50 && q_exp.size() != 0; i++) cyc();
    if (q_exp.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q_exp.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
